// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-1 main control FSM with a ready-handshaked shared memory port.
// Define MC_JUMP_EN to decode opcode 000010 as j through the JUMP state.
module mc_control_fsm (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       IorD_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       PCWrite_o,
  output logic       Branch_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       AluSrcA_o,
  output logic [1:0] AluSrcB_o,
  output logic [1:0] PcSrc_o,
  output logic [1:0] AluOp_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state, next;

  logic is_mem, is_r, is_beq, is_addi;
  logic req, mw, irw, pcw, br, rw, ill;

  assign is_mem  = (op_i == OP_LW) || (op_i == OP_SW);
  assign is_r    = (op_i == OP_RTYP);
  assign is_beq  = (op_i == OP_BEQ);
  assign is_addi = (op_i == OP_ADDI);
`ifdef MC_JUMP_EN
  logic is_j;
  assign is_j    = (op_i == OP_J);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_FETCH;
    else          state <= next;
  end

  always_comb begin
    next       = state;
    req        = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    pcw        = 1'b0;
    br         = 1'b0;
    rw         = 1'b0;
    ill        = 1'b0;
    IorD_o     = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    AluSrcA_o  = 1'b0;
    AluSrcB_o  = 2'b00;
    PcSrc_o    = 2'b00;
    AluOp_o    = 2'b00;
    unique case (state)
      S_FETCH: begin
        req       = 1'b1;
        AluSrcB_o = 2'b01;
        irw       = mem_ready_i;
        pcw       = mem_ready_i;
        if (mem_ready_i) next = S_DECODE;
      end
      S_DECODE: begin
        AluSrcB_o = 2'b11;
        unique case (1'b1)
          is_mem:  next = S_MEMADR;
          is_r:    next = S_EXEC;
          is_beq:  next = S_BRANCH;
          is_addi: next = S_ADDIEX;
`ifdef MC_JUMP_EN
          is_j:    next = S_JUMP;
`endif
          default: begin
            next = S_FETCH;
            ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        AluSrcA_o = 1'b1;
        AluSrcB_o = 2'b10;
        next = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req    = 1'b1;
        IorD_o = 1'b1;
        if (mem_ready_i) next = S_MEMWB;
      end
      S_MEMWB: begin
        rw         = 1'b1;
        MemtoReg_o = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWR: begin
        req    = 1'b1;
        IorD_o = 1'b1;
        mw     = 1'b1;
        if (mem_ready_i) next = S_FETCH;
      end
      S_EXEC: begin
        AluSrcA_o = 1'b1;
        AluOp_o   = 2'b10;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        rw       = 1'b1;
        RegDst_o = 1'b1;
        next     = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA_o = 1'b1;
        AluOp_o   = 2'b01;
        PcSrc_o   = 2'b01;
        br        = 1'b1;
        next      = S_FETCH;
      end
      S_ADDIEX: begin
        AluSrcA_o = 1'b1;
        AluSrcB_o = 2'b10;
        next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw   = 1'b1;
        next = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        PcSrc_o = 2'b10;
        pcw     = 1'b1;
        next    = S_FETCH;
      end
`endif
      default: next = S_FETCH;
    endcase
  end

  // strobes are masked while reset is held; selects keep FETCH values
  assign mem_req_o  = req & rst_n_i;
  assign MemWrite_o = mw & rst_n_i;
  assign IRWrite_o  = irw & rst_n_i;
  assign PCWrite_o  = pcw & rst_n_i;
  assign Branch_o   = br & rst_n_i;
  assign RegWrite_o = rw & rst_n_i;
  assign illegal_o  = ill & rst_n_i;
  assign state_o    = state;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the multicycle MIPS-1 core. It sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback steps per instruction. It drives the 2-bit ALU operation class consumed by the ALU decoder, which maps it together with `funct` to the 3-bit ALU control. It also arbitrates the single memory port between instruction fetch and data access using a ready handshake.

## Interface
Parameters: none.

Ports:
- `clk_i` input 1: core clock, all state updates on its rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `op_i` input 6: opcode field from the instruction register.
- `mem_ready_i` input 1: memory completes the current request this cycle.
- `mem_req_o` output 1: memory access request.
- `IorD_o` output 1: address select, 0 = PC, 1 = ALUOut.
- `MemWrite_o` output 1: memory write strobe.
- `IRWrite_o` output 1: instruction register load.
- `PCWrite_o` output 1: unconditional PC load.
- `Branch_o` output 1: conditional PC load, gated by Zero outside this block.
- `RegWrite_o` output 1: register file write.
- `RegDst_o` output 1: destination select, 0 = rt, 1 = rd.
- `MemtoReg_o` output 1: writeback select, 0 = ALUOut, 1 = memory data.
- `AluSrcA_o` output 1: ALU A select, 0 = PC, 1 = A.
- `AluSrcB_o` output 2: ALU B select, 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `PcSrc_o` output 2: PC source, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `AluOp_o` output 2: 00 = add, 01 = subtract, 10 = decode `funct`.
- `illegal_o` output 1: unrecognised opcode seen in DECODE.
- `state_o` output 4: current state, for debug.

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and return to FETCH on the next edge.

Outputs are decoded combinationally from the registered state. Every output not listed for a state is 0.
- FETCH: `mem_req_o`=1, `IorD_o`=0, `AluSrcB_o`=01, `AluOp_o`=00, `PcSrc_o`=00. `IRWrite_o` = `PCWrite_o` = `mem_ready_i`. Stays in FETCH until `mem_ready_i`, then goes to DECODE.
- DECODE: `AluSrcB_o`=11, `AluOp_o`=00. Next state by `op_i`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with `illegal_o`=1 for this cycle.
- MEMADR: `AluSrcA_o`=1, `AluSrcB_o`=10, `AluOp_o`=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req_o`=1, `IorD_o`=1. Holds until `mem_ready_i`, then goes to MEMWB.
- MEMWB: `RegWrite_o`=1, `MemtoReg_o`=1, `RegDst_o`=0. Then FETCH.
- MEMWR: `mem_req_o`=1, `IorD_o`=1, `MemWrite_o`=1, held every wait cycle. Goes to FETCH when `mem_ready_i`.
- EXEC: `AluSrcA_o`=1, `AluSrcB_o`=00, `AluOp_o`=10. Then ALUWB.
- ALUWB: `RegWrite_o`=1, `RegDst_o`=1, `MemtoReg_o`=0. Then FETCH.
- BRANCH: `AluSrcA_o`=1, `AluSrcB_o`=00, `AluOp_o`=01, `PcSrc_o`=01, `Branch_o`=1. Then FETCH.
- ADDIEX: `AluSrcA_o`=1, `AluSrcB_o`=10, `AluOp_o`=00. Then ADDIWB.
- ADDIWB: `RegWrite_o`=1, `RegDst_o`=0, `MemtoReg_o`=0. Then FETCH.
- JUMP: `PcSrc_o`=10, `PCWrite_o`=1. Then FETCH.

## Timing
Reset:
- While `rst_n_i`=0, state is FETCH immediately (asynchronous).
- During reset all strobes are forced to 0: `mem_req_o`, `MemWrite_o`, `IRWrite_o`, `PCWrite_o`, `Branch_o`, `RegWrite_o`, `illegal_o`.
- Select outputs show FETCH values during reset; `state_o`=0.
- Reset asserted mid-instruction, including during a memory wait, abandons the instruction with no further writes.
- The first FETCH request is issued in the first cycle after `rst_n_i` rises.

Latency, with `mem_ready_i` held at 1:
- lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles; illegal opcode 2 cycles.
- Each cycle of `mem_ready_i`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.

Handshake:
- `mem_req_o` and the address select stay stable until the cycle `mem_ready_i`=1.
- The transfer completes on that edge.
- `mem_ready_i` is ignored in states where `mem_req_o`=0.

## Configuration
- `MC_JUMP_EN` defined: the JUMP state exists and opcode 000010 is decoded as j.
- `MC_JUMP_EN` undefined:
  - opcode 000010 is illegal (`illegal_o`=1, return to FETCH);
  - state 11 is treated as unreachable (returns to FETCH);
  - `PcSrc_o` never equals 10.

## Test plan
- Reset, then lw (`op_i`=100011), ready tied to 1 → states 0,1,2,3,4,0; `RegWrite_o`=1 with `MemtoReg_o`=1 only in cycle 5; `IRWrite_o` pulses once.
- sw with `mem_ready_i`=0 for 2 cycles in MEMWR → `MemWrite_o`=1 for 3 consecutive cycles, then FETCH; instruction takes 6 cycles.
- R-type then beq back-to-back → `AluOp_o`=10 in EXEC, 01 in BRANCH; `Branch_o`=1 for exactly one cycle with `PcSrc_o`=01.
- Opcode 111111 → `illegal_o`=1 for one cycle in DECODE, next state FETCH, no `RegWrite_o`/`MemWrite_o`/`PCWrite_o` after fetch.
- `rst_n_i` dropped asynchronously mid-MEMRD with ready low → `state_o`=0 immediately; all strobes 0; fetch resumes the cycle after release.
- j (`op_i`=000010) → with `MC_JUMP_EN`: 3 cycles, `PcSrc_o`=10 and `PCWrite_o`=1 in cycle 3; without it: `illegal_o`=1 and no PC write beyond fetch.
